// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and constants for the gray_counter slice.
// The conversion functions work on a 32-bit word, so they serve any width up to GRAY_MAX_N.
package gray_pkg;

    localparam int GRAY_DEFAULT_N = 4;
    localparam int GRAY_MAX_N     = 32;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    typedef logic [GRAY_MAX_N-1:0] gray_word_t;

    function automatic gray_word_t bin_to_gray(input gray_word_t b);
        return b ^ (b >> 1);
    endfunction

    // A zero-extended Gray word decodes correctly because the unused upper bits contribute nothing.
    function automatic gray_word_t gray_to_bin(input gray_word_t g);
        gray_word_t b;
        b = '0;
        for (int i = 0; i < GRAY_MAX_N; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_counter_if.sv
// Control and status bundle between a gray_counter and the logic that drives it.
interface gray_counter_if #(
    parameter int N = gray_pkg::GRAY_DEFAULT_N
);
    logic         en;
    logic         up;
    logic         load;
    logic [N-1:0] load_gray;
    logic [N-1:0] bin;
    logic [N-1:0] gray;
    logic         wrap;

    modport master (
        output en, up, load, load_gray,
        input  bin, gray, wrap
    );

    modport slave (
        input  en, up, load, load_gray,
        output bin, gray, wrap
    );
endinterface

// File: rtl/gray_counter_gray2binary.sv
// Combinational Gray-to-binary decode used on the counter load path.
module gray2binary #(
    parameter int N = 4
) (
    input  logic [N-1:0] gray_i,
    output logic [N-1:0] bin_o
);

    // Each binary bit is the parity of the Gray bits at and above it.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin_o[i] = ^(gray_i >> i);
    end

endmodule

// File: rtl/gray_counter.sv
// Registered N-bit up/down Gray counter with Gray-coded parallel load.
// Define GRAY_CNT_SAT_EN to saturate at the ends instead of wrapping.
module gray_counter
    import gray_pkg::*;
#(
    parameter int N = GRAY_DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst,
    gray_counter_if.slave  bus
);

    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_ONE = N'(1);

    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic [N-1:0] load_bin;

    gray2binary #(.N(N)) u_load_dec (
        .gray_i (bus.load_gray),
        .bin_o  (load_bin)
    );

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (bus.load) begin
            bin_d = load_bin;
        end else if (bus.en) begin
            if (bus.up == DIR_UP) begin
                if (bin_q == CNT_MAX) begin
                    wrap_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                    bin_d  = bin_q;
`else
                    bin_d  = '0;
`endif
                end else begin
                    bin_d = bin_q + CNT_ONE;
                end
            end else begin
                if (bin_q == '0) begin
                    wrap_d = 1'b1;
`ifdef GRAY_CNT_SAT_EN
                    bin_d  = bin_q;
`else
                    bin_d  = CNT_MAX;
`endif
                end else begin
                    bin_d = bin_q - CNT_ONE;
                end
            end
        end
        // Encode from the next binary value so both views update on the same edge.
        gray_d = N'(bin_to_gray(gray_word_t'(bin_d)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.bin  = bin_q;
    assign bus.gray = gray_q;
    assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Directed checks of gray_counter at N=4 plus a model-checked random run at N=8.
module tb_gray_counter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic [3:0] gt [16];
    logic [3:0] prev_gray;

    gray_counter_if #(.N(4)) if4 ();
    gray_counter_if #(.N(8)) if8 ();

    gray_counter #(.N(4)) u_dut4 (.clk(clk), .rst(rst), .bus(if4));
    gray_counter #(.N(8)) u_dut8 (.clk(clk), .rst(rst), .bus(if8));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input int b, input int g, input int w);
        chk({tag, ".bin"},  32'(if4.bin),  32'(b));
        chk({tag, ".gray"}, 32'(if4.gray), 32'(g));
        chk({tag, ".wrap"}, 32'(if4.wrap), 32'(w));
    endtask

    function automatic logic [7:0] g2b8(input logic [7:0] g);
        logic [7:0] b;
        b[7] = g[7];
        for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    initial begin
        n_checks = 0;
        n_fail   = 0;
        gt = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
               4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
        rst = 1'b1;
        if4.en = 1'b0; if4.up = 1'b1; if4.load = 1'b0; if4.load_gray = '0;
        if8.en = 1'b0; if8.up = 1'b1; if8.load = 1'b0; if8.load_gray = '0;
        tick();
        chk4("reset", 0, 0, 0);

        // Count up through the full cycle
        rst = 1'b0;
        if4.en = 1'b1; if4.up = 1'b1;
        prev_gray = if4.gray;
        for (int i = 1; i < 16; i++) begin
            tick();
            chk4("up", i, int'(gt[i]), 0);
            chk("up.hamming", 32'($countones(if4.gray ^ prev_gray)), 32'd1);
            prev_gray = if4.gray;
        end
`ifndef GRAY_CNT_SAT_EN
        tick();
        chk4("wrap_up", 0, 0, 1);
        chk("wrap_up.hamming", 32'($countones(if4.gray ^ prev_gray)), 32'd1);
        if4.en = 1'b0;
        tick();
        chk4("wrap_up_clear", 0, 0, 0);
        if4.en = 1'b1; if4.up = 1'b0;
        tick();
        chk4("wrap_down", 15, 4'b1000, 1);
        if4.en = 1'b0;
        tick();
        chk4("wrap_down_clear", 15, 4'b1000, 0);
`else
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("sat_up", 15, 4'b1000, 1);
        end
        if4.up = 1'b0;
        tick();
        chk4("sat_release", 14, 4'b1001, 0);
        if4.en = 1'b0; if4.load = 1'b1; if4.load_gray = 4'b0000;
        tick();
        chk4("sat_load0", 0, 0, 0);
        if4.load = 1'b0; if4.en = 1'b1; if4.up = 1'b0;
        tick();
        chk4("sat_down", 0, 0, 1);
        if4.en = 1'b0;
        tick();
        chk4("sat_down_clear", 0, 0, 0);
`endif

        // Gray load then count down
        if4.load = 1'b1; if4.en = 1'b0; if4.load_gray = 4'b1101;
        tick();
        chk4("load_1101", 9, 4'b1101, 0);
        if4.load = 1'b0; if4.en = 1'b1; if4.up = 1'b0;
        tick();
        chk4("down_8", 8, 4'b1100, 0);
        tick();
        chk4("down_7", 7, 4'b0100, 0);

        // Priority: rst over load over en
        rst = 1'b1; if4.load = 1'b1; if4.en = 1'b1; if4.load_gray = 4'b1111;
        tick();
        chk4("rst_over_load", 0, 0, 0);
        rst = 1'b0; if4.up = 1'b1; if4.load_gray = 4'b0110;
        tick();
        chk4("load_over_en", 4, 4'b0110, 0);
        if4.load_gray = 4'b1000;
        tick();
        chk4("load_max", 15, 4'b1000, 0);
        tick();
        chk4("load_blocks_wrap", 15, 4'b1000, 0);
        if4.load = 1'b0;
        tick();
`ifndef GRAY_CNT_SAT_EN
        chk4("wrap_after_load", 0, 0, 1);
`else
        chk4("sat_after_load", 15, 4'b1000, 1);
`endif

        // Reset mid-count, then resume from zero
        rst = 1'b1;
        tick();
        chk4("rst_midcount", 0, 0, 0);
        rst = 1'b0;
        tick();
        chk4("resume_1", 1, 4'b0001, 0);
        tick();
        chk4("resume_2", 2, 4'b0011, 0);
        if4.en = 1'b0;

        // Random run at N=8 against a behavioural model
        begin
            int m_bin;
            int m_wrap;
            int r;
            int sel;
            for (int c = 0; c < 1000; c++) begin
                r = int'($urandom_range(0, 15));
                sel = int'($urandom_range(0, 3));
                if8.load = (r == 0);
                if8.en   = (r < 12);
                if8.up   = 1'($urandom_range(0, 1));
                if8.load_gray = (sel == 0) ? 8'h00 :
                                (sel == 1) ? 8'h80 : 8'($urandom_range(0, 255));
                m_wrap = 0;
                if (if8.load) begin
                    m_bin = int'(g2b8(if8.load_gray));
                end else if (if8.en) begin
                    if (if8.up) begin
                        if (m_bin == 255) begin
                            m_wrap = 1;
`ifndef GRAY_CNT_SAT_EN
                            m_bin = 0;
`endif
                        end else m_bin = m_bin + 1;
                    end else begin
                        if (m_bin == 0) begin
                            m_wrap = 1;
`ifndef GRAY_CNT_SAT_EN
                            m_bin = 255;
`endif
                        end else m_bin = m_bin - 1;
                    end
                end
                tick();
                chk("rnd.bin",  32'(if8.bin),  32'(m_bin));
                chk("rnd.gray", 32'(if8.gray), 32'(m_bin ^ (m_bin >> 1)));
                chk("rnd.wrap", 32'(if8.wrap), 32'(m_wrap));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
